// File: rtl/dispatch_ctrl_pkg.sv
// Shared types for the dispatch slice: opcode enumeration, queue/FSM encodings,
// queue entry and dispatch payload records, and the head classification helper.
package dispatch_ctrl_pkg;

  typedef logic [31:0] ins_t;
  typedef logic [31:0] data_t;
  typedef logic [4:0]  reg_pos_t;

  typedef enum logic [5:0] {
    OPENUM_NOP = 6'd0,
    OPENUM_LUI, OPENUM_AUIPC, OPENUM_JAL, OPENUM_JALR,
    OPENUM_BEQ, OPENUM_BNE, OPENUM_BLT, OPENUM_BGE, OPENUM_BLTU, OPENUM_BGEU,
    OPENUM_LB, OPENUM_LH, OPENUM_LW, OPENUM_LBU, OPENUM_LHU,
    OPENUM_SB, OPENUM_SH, OPENUM_SW,
    OPENUM_ADDI, OPENUM_SLTI, OPENUM_SLTIU, OPENUM_XORI, OPENUM_ORI, OPENUM_ANDI,
    OPENUM_SLLI, OPENUM_SRLI, OPENUM_SRAI,
    OPENUM_ADD, OPENUM_SUB, OPENUM_SLL, OPENUM_SLT, OPENUM_SLTU,
    OPENUM_XOR, OPENUM_SRL, OPENUM_SRA, OPENUM_OR, OPENUM_AND
  } openum_t;

  // Loads and stores are encoded contiguously so MEM membership is a range test.
  localparam openum_t OPENUM_MEM_FIRST = OPENUM_LB;
  localparam openum_t OPENUM_MEM_LAST  = OPENUM_SW;

  typedef enum logic [1:0] {
    IQ_RUN   = 2'd0,
    IQ_STALL = 2'd1,
    IQ_FLUSH = 2'd2
  } iq_state_t;

  typedef enum logic [1:0] {
    CLS_NOP = 2'd0,
    CLS_ALU = 2'd1,
    CLS_MEM = 2'd2
  } op_class_t;

  typedef struct packed {
    ins_t  inst;
    data_t pc;
    logic  pred_jump;
  } iq_entry_t;

  typedef struct packed {
    openum_t  openum;
    reg_pos_t rd;
    reg_pos_t rs1;
    reg_pos_t rs2;
    data_t    imm;
    data_t    pc;
    logic     pred_jump;
    logic     is_jump;
    logic     is_store;
  } disp_payload_t;

  function automatic op_class_t op_class(input openum_t op);
    if (op == OPENUM_NOP) return CLS_NOP;
    if (op >= OPENUM_MEM_FIRST && op <= OPENUM_MEM_LAST) return CLS_MEM;
    return CLS_ALU;
  endfunction

endpackage

// File: rtl/dispatch_ctrl_if.sv
// Bundle between dispatch_ctrl and its neighbours: fetch push side, the external
// decoder loop, downstream almost-full flags and the registered dispatch outputs.
interface dispatch_ctrl_if;
  import dispatch_ctrl_pkg::*;

  logic     fetch_valid;
  ins_t     fetch_inst;
  data_t    fetch_pc;
  logic     fetch_pred_jump;
  logic     iq_full;

  ins_t     dec_inst;
  openum_t  dec_openum;
  reg_pos_t dec_rd;
  reg_pos_t dec_rs1;
  reg_pos_t dec_rs2;
  data_t    dec_imm;
  logic     dec_is_jump;
  logic     dec_is_store;

  logic     rs_full;
  logic     lsb_full;
  logic     rob_full;

  logic     disp_rs;
  logic     disp_lsb;
  logic     disp_rob;
  openum_t  disp_openum;
  reg_pos_t disp_rd;
  reg_pos_t disp_rs1;
  reg_pos_t disp_rs2;
  data_t    disp_imm;
  data_t    disp_pc;
  logic     disp_pred_jump;
  logic     disp_is_jump;
  logic     disp_is_store;

  modport master (
    input  fetch_valid, fetch_inst, fetch_pc, fetch_pred_jump,
    input  dec_openum, dec_rd, dec_rs1, dec_rs2, dec_imm, dec_is_jump, dec_is_store,
    input  rs_full, lsb_full, rob_full,
    output iq_full, dec_inst,
    output disp_rs, disp_lsb, disp_rob, disp_openum, disp_rd, disp_rs1, disp_rs2,
    output disp_imm, disp_pc, disp_pred_jump, disp_is_jump, disp_is_store
  );

  modport slave (
    output fetch_valid, fetch_inst, fetch_pc, fetch_pred_jump,
    output dec_openum, dec_rd, dec_rs1, dec_rs2, dec_imm, dec_is_jump, dec_is_store,
    output rs_full, lsb_full, rob_full,
    input  iq_full, dec_inst,
    input  disp_rs, disp_lsb, disp_rob, disp_openum, disp_rd, disp_rs1, disp_rs2,
    input  disp_imm, disp_pc, disp_pred_jump, disp_is_jump, disp_is_store
  );

endinterface

// File: rtl/dispatch_ctrl_inst_queue.sv
// Circular instruction FIFO with synchronous clear; the head word is read
// combinationally because the decoder works directly off it.
module inst_queue #(
  parameter int DEPTH_LOG = 3,
  parameter int WIDTH     = 65
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_i,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [WIDTH-1:0]     push_data_i,
  output logic [WIDTH-1:0]     head_data_o,
  output logic [DEPTH_LOG:0]   count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int                 DEPTH    = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] CNT_FULL = (DEPTH_LOG + 1)'(DEPTH);
  localparam logic [DEPTH_LOG:0] CNT_ONE  = (DEPTH_LOG + 1)'(1);
  localparam logic [DEPTH_LOG-1:0] PTR_ONE = DEPTH_LOG'(1);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG-1:0] head_q, tail_q;
  logic [DEPTH_LOG:0]   count_q;
  logic                 push_ok, pop_ok;

  assign full_o      = (count_q == CNT_FULL);
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;
  assign head_data_o = mem_q[head_q];
  // A full queue refuses pushes even when the head leaves in the same cycle.
  assign push_ok     = push_i & ~full_o & ~clear_i;
  assign pop_ok      = pop_i & ~empty_o & ~clear_i;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[tail_q] <= push_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) tail_q <= tail_q + PTR_ONE;
      if (pop_ok)  head_q <= head_q + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dispatch_ctrl.sv
// Dispatch sequencer: queues fetch words, classifies the decoded head and issues one
// registered RS/LSB/ROB dispatch per cycle. Optional counters under DISPATCH_PERF_EN.
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int IQ_DEPTH_LOG = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rdy,
  input  logic            rollback,
  dispatch_ctrl_if.master bus
`ifdef DISPATCH_PERF_EN
  ,
  output logic [31:0]     perf_disp_cnt,
  output logic [31:0]     perf_stall_cnt,
  output logic [15:0]     perf_drop_cnt
`endif
);

  iq_state_t          state_q, state_d;
  iq_entry_t          push_entry, head_entry;
  logic [IQ_DEPTH_LOG:0] iq_count;
  logic               iq_full_w, iq_empty;
  op_class_t          head_cls;
  logic               target_full, push_en, pop_en, dispatch_en, clear_en;
  disp_payload_t      payload_q, payload_d;
  logic               disp_rs_q, disp_lsb_q, disp_rob_q;

  assign push_entry = '{inst: bus.fetch_inst, pc: bus.fetch_pc, pred_jump: bus.fetch_pred_jump};
  assign head_cls   = op_class(bus.dec_openum);

  inst_queue #(
    .DEPTH_LOG (IQ_DEPTH_LOG),
    .WIDTH     ($bits(iq_entry_t))
  ) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (clear_en),
    .push_i      (push_en),
    .pop_i       (pop_en),
    .push_data_i (push_entry),
    .head_data_o (head_entry),
    .count_o     (iq_count),
    .full_o      (iq_full_w),
    .empty_o     (iq_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IQ_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    target_full = 1'b0;
    case (head_cls)
      CLS_MEM: target_full = bus.lsb_full | bus.rob_full;
      CLS_ALU: target_full = bus.rs_full | bus.rob_full;
      default: target_full = 1'b0;
    endcase

    // A back-end stall only holds the head; fetch keeps filling until the queue is full.
    push_en     = rdy & bus.fetch_valid & ~iq_full_w & (state_q != IQ_FLUSH) & ~rollback;
    pop_en      = rdy & (state_q == IQ_RUN) & (iq_count != '0) & ~rollback & ~target_full;
    dispatch_en = pop_en & (head_cls != CLS_NOP);
    clear_en    = rdy & rollback;

    state_d = state_q;
    if (rdy) begin
      if (rollback) begin
        state_d = IQ_FLUSH;
      end else begin
        case (state_q)
          IQ_RUN:   if (!iq_empty && target_full) state_d = IQ_STALL;
          IQ_STALL: if (!target_full) state_d = IQ_RUN;
          IQ_FLUSH: state_d = IQ_RUN;
          default:  state_d = IQ_RUN;
        endcase
      end
    end
  end

  assign payload_d = '{
    openum:    bus.dec_openum,
    rd:        bus.dec_rd,
    rs1:       bus.dec_rs1,
    rs2:       bus.dec_rs2,
    imm:       bus.dec_imm,
    pc:        head_entry.pc,
    pred_jump: head_entry.pred_jump,
    is_jump:   bus.dec_is_jump,
    is_store:  bus.dec_is_store
  };

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_rs_q  <= 1'b0;
      disp_lsb_q <= 1'b0;
      disp_rob_q <= 1'b0;
      payload_q  <= '0;
    end else begin
      disp_rs_q  <= dispatch_en & (head_cls == CLS_ALU);
      disp_lsb_q <= dispatch_en & (head_cls == CLS_MEM);
      disp_rob_q <= dispatch_en;
      if (dispatch_en) payload_q <= payload_d;
    end
  end

  assign bus.iq_full        = iq_full_w;
  assign bus.dec_inst       = iq_empty ? '0 : head_entry.inst;
  assign bus.disp_rs        = disp_rs_q;
  assign bus.disp_lsb       = disp_lsb_q;
  assign bus.disp_rob       = disp_rob_q;
  assign bus.disp_openum    = payload_q.openum;
  assign bus.disp_rd        = payload_q.rd;
  assign bus.disp_rs1       = payload_q.rs1;
  assign bus.disp_rs2       = payload_q.rs2;
  assign bus.disp_imm       = payload_q.imm;
  assign bus.disp_pc        = payload_q.pc;
  assign bus.disp_pred_jump = payload_q.pred_jump;
  assign bus.disp_is_jump   = payload_q.is_jump;
  assign bus.disp_is_store  = payload_q.is_store;

`ifdef DISPATCH_PERF_EN
  logic [31:0] perf_disp_q, perf_stall_q;
  logic [15:0] perf_drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_disp_q  <= '0;
      perf_stall_q <= '0;
      perf_drop_q  <= '0;
    end else begin
      if (dispatch_en)                         perf_disp_q  <= perf_disp_q + 32'd1;
      if (rdy && state_q == IQ_STALL)          perf_stall_q <= perf_stall_q + 32'd1;
      if (pop_en && head_cls == CLS_NOP)       perf_drop_q  <= perf_drop_q + 16'd1;
    end
  end

  assign perf_disp_cnt  = perf_disp_q;
  assign perf_stall_cnt = perf_stall_q;
  assign perf_drop_cnt  = perf_drop_q;
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl; a tiny addi/sw decoder stands in for the real one.
module tb_dispatch_ctrl;
  import dispatch_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b0;
  logic rollback = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  dispatch_ctrl_if bus();

`ifdef DISPATCH_PERF_EN
  logic [31:0] perf_disp_cnt, perf_stall_cnt;
  logic [15:0] perf_drop_cnt;
`endif

  dispatch_ctrl #(.IQ_DEPTH_LOG(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rdy      (rdy),
    .rollback (rollback),
    .bus      (bus)
`ifdef DISPATCH_PERF_EN
    ,
    .perf_disp_cnt  (perf_disp_cnt),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_drop_cnt  (perf_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Decoder stand-in: only addi and sw are legal, everything else decodes to NOP.
  always_comb begin
    bus.dec_openum   = OPENUM_NOP;
    bus.dec_rd       = '0;
    bus.dec_rs1      = '0;
    bus.dec_rs2      = '0;
    bus.dec_imm      = '0;
    bus.dec_is_jump  = 1'b0;
    bus.dec_is_store = 1'b0;
    if (bus.dec_inst[6:0] == 7'h13 && bus.dec_inst[14:12] == 3'b000) begin
      bus.dec_openum = OPENUM_ADDI;
      bus.dec_rd     = bus.dec_inst[11:7];
      bus.dec_rs1    = bus.dec_inst[19:15];
      bus.dec_imm    = {{20{bus.dec_inst[31]}}, bus.dec_inst[31:20]};
    end else if (bus.dec_inst[6:0] == 7'h23 && bus.dec_inst[14:12] == 3'b010) begin
      bus.dec_openum   = OPENUM_SW;
      bus.dec_rs1      = bus.dec_inst[19:15];
      bus.dec_rs2      = bus.dec_inst[24:20];
      bus.dec_imm      = {{20{bus.dec_inst[31]}}, bus.dec_inst[31:25], bus.dec_inst[11:7]};
      bus.dec_is_store = 1'b1;
    end
  end

  function automatic logic [31:0] addi_w(input int r);
    return {12'(r), 5'd0, 3'b000, 5'(r), 7'h13};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] inst, input logic [31:0] pc);
    bus.fetch_valid = 1'b1;
    bus.fetch_inst  = inst;
    bus.fetch_pc    = pc;
    step();
    bus.fetch_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) step();
    n_cmp++; if ({bus.disp_rs, bus.disp_lsb, bus.disp_rob} !== 3'b000) begin n_bad++; $display("FAIL reset_strobes: got %b want 000", {bus.disp_rs, bus.disp_lsb, bus.disp_rob}); end
    n_cmp++; if (bus.iq_full !== 1'b0) begin n_bad++; $display("FAIL reset_iq_full: got %b want 0", bus.iq_full); end
    n_cmp++; if (bus.dec_inst !== 32'h0) begin n_bad++; $display("FAIL reset_dec_inst: got %h want 0", bus.dec_inst); end
    n_cmp++; if ({bus.disp_pc, bus.disp_imm, bus.disp_rd} !== 69'h0) begin n_bad++; $display("FAIL reset_payload: pc %h imm %h rd %0d want 0", bus.disp_pc, bus.disp_imm, bus.disp_rd); end
`ifdef DISPATCH_PERF_EN
    n_cmp++; if ({perf_disp_cnt, perf_stall_cnt, perf_drop_cnt} !== 80'h0) begin n_bad++; $display("FAIL reset_perf: got %h want 0", {perf_disp_cnt, perf_stall_cnt, perf_drop_cnt}); end
`endif
    rst_n = 1'b1;
    step();
    $display("reset released");
  endtask

  task automatic test_alu_dispatch();
    push(32'h00500093, 32'h100);
    n_cmp++; if (bus.dec_inst !== 32'h00500093) begin n_bad++; $display("FAIL alu_head: got %h want 00500093", bus.dec_inst); end
    step();
    $display("addi dispatch rd=%0d imm=%0d pc=%h", bus.disp_rd, bus.disp_imm, bus.disp_pc);
    n_cmp++; if ({bus.disp_rs, bus.disp_lsb, bus.disp_rob} !== 3'b101) begin n_bad++; $display("FAIL alu_strobes: got %b want 101", {bus.disp_rs, bus.disp_lsb, bus.disp_rob}); end
    n_cmp++; if (bus.disp_rd !== 5'd1 || bus.disp_imm !== 32'd5) begin n_bad++; $display("FAIL alu_rd_imm: got rd %0d imm %0d want 1 5", bus.disp_rd, bus.disp_imm); end
    n_cmp++; if (bus.disp_pc !== 32'h100 || bus.disp_openum !== OPENUM_ADDI) begin n_bad++; $display("FAIL alu_pc_op: got pc %h op %0d want 100 %0d", bus.disp_pc, bus.disp_openum, OPENUM_ADDI); end
    step();
    n_cmp++; if ({bus.disp_rs, bus.disp_lsb, bus.disp_rob} !== 3'b000) begin n_bad++; $display("FAIL alu_one_cycle: got %b want 000", {bus.disp_rs, bus.disp_lsb, bus.disp_rob}); end
    n_cmp++; if (bus.dec_inst !== 32'h0) begin n_bad++; $display("FAIL alu_empty: got %h want 0", bus.dec_inst); end
  endtask

  task automatic test_mem_stall();
    bus.lsb_full = 1'b1;
    push(32'h0020A423, 32'h104);
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++; if ({bus.disp_rs, bus.disp_lsb, bus.disp_rob} !== 3'b000) begin n_bad++; $display("FAIL stall_no_strobe: cycle %0d got %b want 000", c, {bus.disp_rs, bus.disp_lsb, bus.disp_rob}); end
    end
    n_cmp++; if (bus.dec_inst !== 32'h0020A423) begin n_bad++; $display("FAIL stall_head: got %h want 0020a423", bus.dec_inst); end
    bus.lsb_full = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.disp_rob) break;
    end
    $display("sw dispatch imm=%0d rs1=%0d rs2=%0d", bus.disp_imm, bus.disp_rs1, bus.disp_rs2);
    n_cmp++; if ({bus.disp_rs, bus.disp_lsb, bus.disp_rob} !== 3'b011) begin n_bad++; $display("FAIL mem_strobes: got %b want 011", {bus.disp_rs, bus.disp_lsb, bus.disp_rob}); end
    n_cmp++; if (bus.disp_imm !== 32'd8 || bus.disp_rd !== 5'd0 || bus.disp_is_store !== 1'b1) begin n_bad++; $display("FAIL mem_payload: got imm %0d rd %0d st %b want 8 0 1", bus.disp_imm, bus.disp_rd, bus.disp_is_store); end
    n_cmp++; if (bus.disp_rs1 !== 5'd1 || bus.disp_rs2 !== 5'd2 || bus.disp_pc !== 32'h104) begin n_bad++; $display("FAIL mem_regs_pc: got rs1 %0d rs2 %0d pc %h want 1 2 104", bus.disp_rs1, bus.disp_rs2, bus.disp_pc); end
    step();
    n_cmp++; if (bus.disp_rob !== 1'b0) begin n_bad++; $display("FAIL mem_one_cycle: got %b want 0", bus.disp_rob); end
  endtask

  task automatic test_fill_wrap();
    int got;
    bus.rob_full = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      bus.fetch_valid = 1'b1;
      bus.fetch_inst  = addi_w(k);
      bus.fetch_pc    = 32'h200 + 32'(4 * k);
      step();
      n_cmp++; if (bus.iq_full !== (k >= 8)) begin n_bad++; $display("FAIL fill_iq_full: after push %0d got %b want %b", k, bus.iq_full, (k >= 8)); end
    end
    bus.fetch_valid = 1'b0;
    n_cmp++; if (bus.dec_inst !== addi_w(1)) begin n_bad++; $display("FAIL fill_head: got %h want %h", bus.dec_inst, addi_w(1)); end
    bus.rob_full = 1'b0;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.disp_rob) begin
        got++;
        $display("drain dispatch %0d rd=%0d pc=%h", got, bus.disp_rd, bus.disp_pc);
        n_cmp++; if (bus.disp_rd !== 5'(got) || bus.disp_pc !== 32'h200 + 32'(4 * got)) begin n_bad++; $display("FAIL drain_order: got rd %0d pc %h want %0d %h", bus.disp_rd, bus.disp_pc, got, 32'h200 + 32'(4 * got)); end
      end
    end
    n_cmp++; if (got !== 8) begin n_bad++; $display("FAIL drain_count: got %0d want 8", got); end
    n_cmp++; if (bus.dec_inst !== 32'h0 || bus.iq_full !== 1'b0) begin n_bad++; $display("FAIL drain_empty: got inst %h full %b want 0 0", bus.dec_inst, bus.iq_full); end
  endtask

  task automatic test_rollback();
    bus.rob_full = 1'b1;
    for (int k = 1; k <= 4; k++) push(addi_w(k), 32'h300 + 32'(4 * k));
    n_cmp++; if (bus.dec_inst !== addi_w(1)) begin n_bad++; $display("FAIL rb_head: got %h want %h", bus.dec_inst, addi_w(1)); end
    rollback = 1'b1;
    bus.rob_full = 1'b0;
    bus.fetch_valid = 1'b1;
    bus.fetch_inst = addi_w(7);
    bus.fetch_pc = 32'h3F0;
    step();
    rollback = 1'b0;
    $display("rollback applied");
    n_cmp++; if ({bus.disp_rs, bus.disp_lsb, bus.disp_rob} !== 3'b000) begin n_bad++; $display("FAIL rb_strobe1: got %b want 000", {bus.disp_rs, bus.disp_lsb, bus.disp_rob}); end
    n_cmp++; if (bus.dec_inst !== 32'h0 || bus.iq_full !== 1'b0) begin n_bad++; $display("FAIL rb_cleared: got inst %h full %b want 0 0", bus.dec_inst, bus.iq_full); end
    step();
    bus.fetch_valid = 1'b0;
    n_cmp++; if ({bus.disp_rs, bus.disp_lsb, bus.disp_rob} !== 3'b000) begin n_bad++; $display("FAIL rb_strobe2: got %b want 000", {bus.disp_rs, bus.disp_lsb, bus.disp_rob}); end
    n_cmp++; if (bus.dec_inst !== 32'h0) begin n_bad++; $display("FAIL rb_flush_push: got %h want 0", bus.dec_inst); end
    push(addi_w(6), 32'h3F8);
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.disp_rob) break;
    end
    $display("post-flush dispatch rd=%0d pc=%h", bus.disp_rd, bus.disp_pc);
    n_cmp++; if (bus.disp_rs !== 1'b1 || bus.disp_rd !== 5'd6 || bus.disp_pc !== 32'h3F8) begin n_bad++; $display("FAIL rb_recover: got rs %b rd %0d pc %h want 1 6 3f8", bus.disp_rs, bus.disp_rd, bus.disp_pc); end
  endtask

  task automatic test_nop_drop();
    bus.fetch_valid = 1'b1;
    bus.fetch_inst  = 32'hFFFFFFFF;
    bus.fetch_pc    = 32'h400;
    step();
    bus.fetch_inst  = addi_w(3);
    bus.fetch_pc    = 32'h404;
    step();
    bus.fetch_valid = 1'b0;
    n_cmp++; if ({bus.disp_rs, bus.disp_lsb, bus.disp_rob} !== 3'b000) begin n_bad++; $display("FAIL nop_no_strobe: got %b want 000", {bus.disp_rs, bus.disp_lsb, bus.disp_rob}); end
    n_cmp++; if (bus.dec_inst !== addi_w(3)) begin n_bad++; $display("FAIL nop_next_head: got %h want %h", bus.dec_inst, addi_w(3)); end
    step();
    $display("after drop dispatch rd=%0d pc=%h", bus.disp_rd, bus.disp_pc);
    n_cmp++; if ({bus.disp_rs, bus.disp_lsb, bus.disp_rob} !== 3'b101 || bus.disp_rd !== 5'd3 || bus.disp_pc !== 32'h404) begin n_bad++; $display("FAIL nop_then_addi: got %b rd %0d pc %h want 101 3 404", {bus.disp_rs, bus.disp_lsb, bus.disp_rob}, bus.disp_rd, bus.disp_pc); end
`ifdef DISPATCH_PERF_EN
    n_cmp++; if (perf_drop_cnt !== 16'd1) begin n_bad++; $display("FAIL perf_drop: got %0d want 1", perf_drop_cnt); end
`endif
    step();
  endtask

  task automatic test_rdy_reset();
    int got;
    bus.rob_full = 1'b1;
    push(addi_w(4), 32'h500);
    step();
    rdy = 1'b0;
    bus.rob_full = 1'b0;
    bus.fetch_valid = 1'b1;
    bus.fetch_inst = addi_w(9);
    bus.fetch_pc = 32'h504;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++; if ({bus.disp_rs, bus.disp_lsb, bus.disp_rob} !== 3'b000) begin n_bad++; $display("FAIL rdy_strobe: cycle %0d got %b want 000", c, {bus.disp_rs, bus.disp_lsb, bus.disp_rob}); end
      n_cmp++; if (bus.dec_inst !== addi_w(4) || bus.disp_rd !== 5'd3) begin n_bad++; $display("FAIL rdy_hold: cycle %0d got head %h rd %0d want %h 3", c, bus.dec_inst, bus.disp_rd, addi_w(4)); end
    end
    rdy = 1'b1;
    bus.fetch_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.disp_rob) begin
        got++;
        $display("resume dispatch rd=%0d pc=%h", bus.disp_rd, bus.disp_pc);
        n_cmp++; if (bus.disp_rd !== 5'd4 || bus.disp_pc !== 32'h500) begin n_bad++; $display("FAIL rdy_resume: got rd %0d pc %h want 4 500", bus.disp_rd, bus.disp_pc); end
      end
    end
    n_cmp++; if (got !== 1) begin n_bad++; $display("FAIL rdy_count: got %0d dispatches want 1", got); end
    bus.rob_full = 1'b1;
    push(addi_w(5), 32'h508);
    step();
    #2 rst_n = 1'b0;
    #1;
    $display("async reset asserted mid-stall");
    n_cmp++; if ({bus.disp_rs, bus.disp_lsb, bus.disp_rob} !== 3'b000 || bus.disp_rd !== 5'd0 || bus.disp_pc !== 32'h0) begin n_bad++; $display("FAIL areset_disp: got %b rd %0d pc %h want 000 0 0", {bus.disp_rs, bus.disp_lsb, bus.disp_rob}, bus.disp_rd, bus.disp_pc); end
    n_cmp++; if (bus.dec_inst !== 32'h0 || bus.iq_full !== 1'b0 || bus.disp_imm !== 32'h0) begin n_bad++; $display("FAIL areset_queue: got inst %h full %b imm %h want 0 0 0", bus.dec_inst, bus.iq_full, bus.disp_imm); end
    step();
    rst_n = 1'b1;
    bus.rob_full = 1'b0;
    step();
  endtask

  initial begin
    bus.fetch_valid     = 1'b0;
    bus.fetch_inst      = '0;
    bus.fetch_pc        = '0;
    bus.fetch_pred_jump = 1'b0;
    bus.rs_full         = 1'b0;
    bus.lsb_full        = 1'b0;
    bus.rob_full        = 1'b0;
    rdy                 = 1'b1;
    test_reset();
    test_alu_dispatch();
    test_mem_stall();
    test_fill_wrap();
    test_rollback();
    test_nop_drop();
    test_rdy_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
